sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 1024: clk cycles between forced refresh slots.
REQ-002 Parameter REFRESH_HOLD, default 32: clk cycles one forced refresh slot keeps the SDRAM interface idle.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 init  in  1  reset; synchronous, active-high.
REQ-005 a_valid, a_addr[24:0], a_wdata[31:0], a_wstrb[3:0]  in  port A request (CPU); a_wstrb==0 means read.
REQ-006 a_ready  out  1; a_rdata[31:0]  out  port A completion pulse and read data.
REQ-007 b_valid, b_addr[24:0], b_wdata[31:0], b_wstrb[3:0]  in  port B request (DMA/video); same encoding as A.
REQ-008 b_ready  out  1; b_rdata[31:0]  out  port B completion pulse and read data.
REQ-009 sd_addr[24:0], sd_we, sd_oe, sd_dqm[3:0], sd_din[31:0]  out  drive the SDRAM controller's addr/we/oeA/dqm/din.
REQ-010 sd_dout[31:0], sd_ready  in  the SDRAM controller's doutA/ready.

Function
REQ-011 States: IDLE, BUSY_A, BUSY_B, DROP, REFRESH. REFRESH exists only with the macro from REQ-030.
REQ-012 IDLE outputs: sd_we=0, sd_oe=0, sd_dqm=0, sd_addr=0, sd_din=0. The SDRAM controller therefore auto-refreshes.
REQ-013 Grant order out of IDLE: a pending refresh wins over both ports.
REQ-014 Next, if only one port is valid, that port wins.
REQ-015 If both ports are valid, the port not granted last wins (round-robin); last_grant resets to B, so A wins the first tie.
REQ-016 Grant: IDLE->BUSY_x on the next edge. Update last_grant and register that port's addr/wdata/wstrb into the sd_* outputs.
REQ-017 sd_addr = {addr[24:2], 2'b00}; addr[1:0] is ignored.
REQ-018 Write (wstrb!=0): sd_we=1, sd_oe=0, sd_dqm=wstrb, sd_din=wdata.
REQ-019 Read (wstrb==0): sd_we=0, sd_oe=1, sd_dqm=0, sd_din=0.
REQ-020 In BUSY_x, all sd_* outputs stay stable until the cycle in which sd_ready is first seen high (a rising edge, detected with a registered previous value).
REQ-021 In that cycle: x_rdata <= sd_dout (reads only; writes leave x_rdata unchanged), x_ready <= 1 for exactly one cycle, all sd_* return to IDLE values, state -> DROP.
REQ-022 DROP holds idle outputs until sd_ready==0, then -> IDLE. The controller's multi-cycle ready pulse must never complete a second transaction.
REQ-023 Latency: x_ready asserts one cycle after sd_ready rises. A port can be granted again at the earliest one cycle after leaving DROP.
REQ-024 Requesters hold valid and request fields stable until ready. The arbiter samples them only at grant; later changes are ignored until the next grant.
REQ-025 a_ready and b_ready are never high in the same cycle. A granted port's ready never fires without its own grant.
REQ-026 Refresh counter: counts clk cycles modulo REFRESH_INTERVAL and sets refresh_pending on wrap. A wrap during BUSY/DROP leaves the flag set until IDLE.
REQ-027 REFRESH: sd_we=sd_oe=0 for REFRESH_HOLD cycles, then -> IDLE. refresh_pending clears on entry. The counter keeps running and does not reload.

Reset
REQ-028 While init=1: state=IDLE, sd_* = IDLE values, a_ready=b_ready=0, a_rdata=b_rdata=0, last_grant=B, refresh counter=0, refresh_pending=0, REFRESH hold counter=0.
REQ-029 init asserted mid-transaction aborts it: no ready is issued for it, and the first grant after init deasserts follows REQ-013 to REQ-015.

Configuration
REQ-030 Macro SDRAM_ARB_REFRESH_EN. Defined: REQ-026/027 refresh counter and REFRESH state are built. Undefined: no counter, no REFRESH state, refresh_pending is constant 0, and refresh relies only on IDLE gaps.

Verification
REQ-031 Single read: a_valid=1, a_addr=0x0000104, a_wstrb=0; model asserts sd_ready high for 2 cycles with sd_dout=0xDEADBEEF -> sd_addr=0x0000104, sd_oe=1; one a_ready pulse; a_rdata=0xDEADBEEF; no b_ready.
REQ-032 Write strobes: b_valid, b_addr=0x1FFFFFF, b_wstrb=4'b0101, b_wdata=0x11223344 -> sd_addr=0x1FFFFFC, sd_we=1, sd_dqm=4'b0101, sd_din=0x11223344 held until sd_ready; one b_ready pulse.
REQ-033 Contention: a_valid and b_valid high together for 4 back-to-back transactions -> grants A,B,A,B; each ready pulses exactly once per transaction.
REQ-034 Refresh (macro on, REFRESH_INTERVAL=64): a_valid held continuously -> every 64 cycles, at the next IDLE, sd_we=sd_oe=0 for exactly 32 cycles before the next A grant. Macro off -> no such idle window.
REQ-035 Reset mid-op: init=1 for 1 cycle while BUSY_A, before sd_ready -> all outputs zero the next cycle, no a_ready for the aborted access; a subsequent tie grants A first.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port (A: CPU, B: DMA/video) round-robin arbiter in front of a single-port SDRAM controller.
// Define SDRAM_ARB_REFRESH_EN to build the periodic forced-refresh slot (REFRESH state).
module sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 1024,
    parameter int REFRESH_HOLD     = 32
) (
    input  logic        clk,
    input  logic        init,
    input  logic        a_valid,
    input  logic [24:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_wstrb,
    output logic        a_ready,
    output logic [31:0] a_rdata,
    input  logic        b_valid,
    input  logic [24:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_wstrb,
    output logic        b_ready,
    output logic [31:0] b_rdata,
    output logic [24:0] sd_addr,
    output logic        sd_we,
    output logic        sd_oe,
    output logic [3:0]  sd_dqm,
    output logic [31:0] sd_din,
    input  logic [31:0] sd_dout,
    input  logic        sd_ready
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_A,
        BUSY_B,
        DROP
`ifdef SDRAM_ARB_REFRESH_EN
        , REFRESH
`endif
    } state_t;

    state_t state;
    logic   last_b;
    logic   sd_ready_q;
    logic   ready_rise;
    logic   refresh_pending;

    // Tie goes to the port that was not granted last.
    logic        pick_a;
    logic [24:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_wstrb;

    assign ready_rise = sd_ready && !sd_ready_q;
    assign pick_a     = a_valid && (!b_valid || last_b);
    assign g_addr     = pick_a ? a_addr  : b_addr;
    assign g_wdata    = pick_a ? a_wdata : b_wdata;
    assign g_wstrb    = pick_a ? a_wstrb : b_wstrb;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{a_addr[1:0], b_addr[1:0]};

`ifdef SDRAM_ARB_REFRESH_EN
    localparam int RCW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int HCW = $clog2(REFRESH_HOLD + 1);

    logic [RCW-1:0] ref_cnt;
    logic [HCW-1:0] hold_cnt;
    logic           ref_wrap;
    logic           refresh_start;

    assign ref_wrap      = (ref_cnt == RCW'(REFRESH_INTERVAL - 1));
    assign refresh_start = (state == IDLE) && refresh_pending;

    // Free-running: never reloaded by a refresh slot. A wrap on the entry cycle wins.
    always_ff @(posedge clk) begin
        if (init) begin
            ref_cnt         <= '0;
            refresh_pending <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            if (ref_wrap)
                refresh_pending <= 1'b1;
            else if (refresh_start)
                refresh_pending <= 1'b0;
        end
    end
`else
    logic [31:0] unused_cfg;
    assign refresh_pending = 1'b0;
    assign unused_cfg      = REFRESH_INTERVAL ^ REFRESH_HOLD ^ {31'd0, refresh_pending};
`endif

    always_ff @(posedge clk) begin
        if (init) begin
            state      <= IDLE;
            last_b     <= 1'b1;
            sd_ready_q <= 1'b0;
            sd_addr    <= '0;
            sd_we      <= 1'b0;
            sd_oe      <= 1'b0;
            sd_dqm     <= '0;
            sd_din     <= '0;
            a_ready    <= 1'b0;
            b_ready    <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
`ifdef SDRAM_ARB_REFRESH_EN
            hold_cnt   <= '0;
`endif
        end else begin
            sd_ready_q <= sd_ready;
            a_ready    <= 1'b0;
            b_ready    <= 1'b0;
            case (state)
                IDLE: begin
`ifdef SDRAM_ARB_REFRESH_EN
                    if (refresh_pending) begin
                        state    <= REFRESH;
                        hold_cnt <= '0;
                    end else
`endif
                    if (a_valid || b_valid) begin
                        state   <= pick_a ? BUSY_A : BUSY_B;
                        last_b  <= !pick_a;
                        sd_addr <= {g_addr[24:2], 2'b00};
                        sd_we   <= |g_wstrb;
                        sd_oe   <= ~|g_wstrb;
                        sd_dqm  <= g_wstrb;
                        sd_din  <= (|g_wstrb) ? g_wdata : 32'd0;
                    end
                end
                BUSY_A, BUSY_B: begin
                    if (ready_rise) begin
                        if (state == BUSY_A) begin
                            a_ready <= 1'b1;
                            if (sd_oe) a_rdata <= sd_dout;
                        end else begin
                            b_ready <= 1'b1;
                            if (sd_oe) b_rdata <= sd_dout;
                        end
                        state   <= DROP;
                        sd_addr <= '0;
                        sd_we   <= 1'b0;
                        sd_oe   <= 1'b0;
                        sd_dqm  <= '0;
                        sd_din  <= '0;
                    end
                end
                // Wait out the rest of the controller's ready pulse.
                DROP: begin
                    if (!sd_ready) state <= IDLE;
                end
`ifdef SDRAM_ARB_REFRESH_EN
                REFRESH: begin
                    if (hold_cnt == HCW'(REFRESH_HOLD - 1))
                        state <= IDLE;
                    else
                        hold_cnt <= hold_cnt + 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
